// File: rtl/ifu_pkg.sv
// Shared fetch-unit types and constants for the instruction byte buffer.
// The invalid-byte value matches the one the fold decoder treats as empty.
package ifu_pkg;
    localparam int IBUF_DEPTH  = 16;
    localparam int IBUF_FILL_W = 4;
    localparam int IBUF_WIN    = 7;

    localparam logic [7:0] INVALID_BYTE = 8'hff;

    typedef logic [3:0] ptr_t;
    typedef logic [4:0] cnt_t;
    typedef logic [IBUF_DEPTH-1:0][7:0] store_t;
    typedef logic [IBUF_WIN-1:0][7:0]   win_t;
endpackage

// File: rtl/ibuf_window_if.sv
// Fetch-fill and decode-window bundle of the instruction byte buffer.
// master = fetch/decode side, slave = the buffer itself.
interface ibuf_window_if;
    logic        flush;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic [2:0]  fill_cnt;
    logic        fill_ready;
    logic [2:0]  drain_cnt;
    logic [7:0]  ibuff_0;
    logic [7:0]  ibuff_1;
    logic [7:0]  ibuff_2;
    logic [7:0]  ibuff_3;
    logic [7:0]  ibuff_4;
    logic [7:0]  ibuff_5;
    logic [7:0]  ibuff_6;
    logic [6:0]  ibuff_vld;
    logic [4:0]  byte_count;
    logic        drain_err;

    modport master (
        output flush, fill_valid, fill_data, fill_cnt, drain_cnt,
        input  fill_ready, ibuff_0, ibuff_1, ibuff_2, ibuff_3,
        input  ibuff_4, ibuff_5, ibuff_6, ibuff_vld,
        input  byte_count, drain_err
    );

    modport slave (
        input  flush, fill_valid, fill_data, fill_cnt, drain_cnt,
        output fill_ready, ibuff_0, ibuff_1, ibuff_2, ibuff_3,
        output ibuff_4, ibuff_5, ibuff_6, ibuff_vld,
        output byte_count, drain_err
    );
endinterface

// File: rtl/ibuf_window_rotmux.sv
// Rotating window mux: oldest 7 bytes from the circular store,
// with slots beyond the current occupancy forced to the invalid byte.
module ibuf_rotmux
    import ifu_pkg::*;
(
    input  store_t              mem,
    input  ptr_t                rd_ptr,
    input  cnt_t                count,
    output win_t                win,
    output logic [IBUF_WIN-1:0] vld
);

    always_comb begin
        win = '0;
        vld = '0;
        for (int i = 0; i < IBUF_WIN; i++) begin
            vld[i] = count > cnt_t'(i);
            win[i] = vld[i] ? mem[rd_ptr + ptr_t'(i)] : INVALID_BYTE;
        end
    end

endmodule

// File: rtl/ibuf_window.sv
// Instruction byte buffer: 16-entry circular store filled up to 4 bytes
// per cycle by fetch and drained by decode through a 7-byte window.
module ibuf_window
    import ifu_pkg::*;
(
    input logic         clk,
    input logic         reset,
    ibuf_window_if.slave bus
);

    store_t mem;
    ptr_t   rd_ptr;
    ptr_t   wr_ptr;
    cnt_t   count;
    logic   drain_err;

    logic   fill_ok;
    logic   fill_ready;
    logic   accept;
    logic   over;
    cnt_t   drain_req;
    cnt_t   eff;
    cnt_t   fill_add;
    win_t   win;
    logic [IBUF_WIN-1:0] vld;

    assign fill_ok    = (bus.fill_cnt != 3'd0) && (bus.fill_cnt <= 3'd4);
    assign fill_ready = count <= cnt_t'(IBUF_DEPTH - IBUF_FILL_W);
    assign accept     = bus.fill_valid && fill_ready && fill_ok;

    // Drain is bounded by the registered occupancy only, so bytes
    // written this cycle can never be consumed in the same cycle.
    assign drain_req = {2'b00, bus.drain_cnt};
    assign over      = drain_req > count;
    assign eff       = over ? count : drain_req;
    assign fill_add  = accept ? {2'b00, bus.fill_cnt} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            drain_err <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            drain_err <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr + ptr_t'(eff);
            wr_ptr    <= wr_ptr + ptr_t'(fill_add);
            count     <= count - eff + fill_add;
            drain_err <= over;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !bus.flush) begin
            for (int i = 0; i < IBUF_FILL_W; i++) begin
                if (3'(i) < bus.fill_cnt)
                    mem[wr_ptr + ptr_t'(i)] <= bus.fill_data[8*i +: 8];
            end
        end
    end

    ibuf_rotmux u_rotmux (
        .mem    (mem),
        .rd_ptr (rd_ptr),
        .count  (count),
        .win    (win),
        .vld    (vld)
    );

    assign bus.fill_ready = fill_ready;
    assign bus.byte_count = count;
    assign bus.drain_err  = drain_err;
    assign bus.ibuff_vld  = vld;
    assign bus.ibuff_0    = win[0];
    assign bus.ibuff_1    = win[1];
    assign bus.ibuff_2    = win[2];
    assign bus.ibuff_3    = win[3];
    assign bus.ibuff_4    = win[4];
    assign bus.ibuff_5    = win[5];
    assign bus.ibuff_6    = win[6];

endmodule

// File: tb/tb_ibuf_window.sv
// Directed vector bench for the instruction byte buffer.
module tb_ibuf_window;

    logic clk;
    logic reset;

    ibuf_window_if bus ();

    ibuf_window dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [31:0] data;
        logic [2:0]  cnt;
        logic [2:0]  drain;
        logic [4:0]  ecount;
        logic [6:0]  evld;
        logic [55:0] ewin;
        logic        erdy;
        logic        eerr;
    } vec_t;

    localparam int NV = 20;
    localparam logic [55:0] ALLFF = 56'hffffffffffffff;

    vec_t v [NV];
    int   checks;
    int   fails;

    wire [55:0] win_act = {bus.ibuff_6, bus.ibuff_5, bus.ibuff_4,
                           bus.ibuff_3, bus.ibuff_2, bus.ibuff_1,
                           bus.ibuff_0};

    always @(negedge clk) begin
        if (!reset)
            assert (bus.byte_count <= 5'd16)
            else $error("FAIL count_bound got %0d", bus.byte_count);
    end

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s v%0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [4:0] ec,
                             input logic [6:0] evl, input logic [55:0] ew,
                             input logic er, input logic ee);
        chk("count", idx, 64'(bus.byte_count), 64'(ec));
        chk("vld", idx, 64'(bus.ibuff_vld), 64'(evl));
        chk("window", idx, 64'(win_act), 64'(ew));
        chk("ready", idx, 64'(bus.fill_ready), 64'(er));
        chk("err", idx, 64'(bus.drain_err), 64'(ee));
    endtask

    task automatic drive(input logic fl, input logic fv,
                         input logic [31:0] d, input logic [2:0] c,
                         input logic [2:0] dr);
        bus.flush      = fl;
        bus.fill_valid = fv;
        bus.fill_data  = d;
        bus.fill_cnt   = c;
        bus.drain_cnt  = dr;
    endtask

    task automatic step(input logic fl, input logic fv,
                        input logic [31:0] d, input logic [2:0] c,
                        input logic [2:0] dr);
        drive(fl, fv, d, c, dr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        v[0]  = '{0, 1, 32'h44332211, 4, 0, 4,  7'h0f, 56'hffffff44332211, 1, 0};
        v[1]  = '{0, 1, 32'h77665544, 3, 0, 7,  7'h7f, 56'h66554444332211, 1, 0};
        v[2]  = '{0, 1, 32'ha3a2a1a0, 4, 0, 11, 7'h7f, 56'h66554444332211, 1, 0};
        v[3]  = '{0, 1, 32'h000000b0, 1, 0, 12, 7'h7f, 56'h66554444332211, 1, 0};
        v[4]  = '{0, 1, 32'hb4b3b2b1, 4, 0, 16, 7'h7f, 56'h66554444332211, 0, 0};
        v[5]  = '{0, 1, 32'heeeeeeee, 4, 0, 16, 7'h7f, 56'h66554444332211, 0, 0};
        v[6]  = '{0, 0, 32'h0,        0, 7, 9,  7'h7f, 56'hb2b1b0a3a2a1a0, 1, 0};
        v[7]  = '{0, 1, 32'hc3c2c1c0, 4, 0, 13, 7'h7f, 56'hb2b1b0a3a2a1a0, 0, 0};
        v[8]  = '{0, 1, 32'hd3d2d1d0, 4, 7, 6,  7'h3f, 56'hffc3c2c1c0b4b3, 1, 0};
        v[9]  = '{0, 1, 32'hd3d2d1d0, 4, 2, 8,  7'h7f, 56'hd2d1d0c3c2c1c0, 1, 0};
        v[10] = '{0, 1, 32'he3e2e1e0, 4, 7, 5,  7'h1f, 56'hffffe3e2e1e0d3, 1, 0};
        v[11] = '{0, 0, 32'h0,        0, 2, 3,  7'h07, 56'hffffffffe3e2e1, 1, 0};
        v[12] = '{0, 1, 32'h000000f5, 1, 5, 1,  7'h01, 56'hfffffffffffff5, 1, 1};
        v[13] = '{0, 0, 32'h0,        0, 0, 1,  7'h01, 56'hfffffffffffff5, 1, 0};
        v[14] = '{0, 1, 32'h00000099, 0, 0, 1,  7'h01, 56'hfffffffffffff5, 1, 0};
        v[15] = '{0, 1, 32'h00000099, 5, 0, 1,  7'h01, 56'hfffffffffffff5, 1, 0};
        v[16] = '{1, 1, 32'h12345678, 4, 2, 0,  7'h00, ALLFF,              1, 0};
        v[17] = '{0, 1, 32'h04030201, 4, 0, 4,  7'h0f, 56'hffffff04030201, 1, 0};
        v[18] = '{0, 0, 32'h0,        0, 5, 0,  7'h00, ALLFF,              1, 1};
        v[19] = '{1, 0, 32'h0,        0, 7, 0,  7'h00, ALLFF,              1, 0};

        drive(0, 0, 32'h0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all(-1, 5'd0, 7'h00, ALLFF, 1'b1, 1'b0);
        step(0, 0, 32'h0, 0, 0);
        check_all(-2, 5'd0, 7'h00, ALLFF, 1'b1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            step(v[i].flush, v[i].fv, v[i].data, v[i].cnt, v[i].drain);
            check_all(i, v[i].ecount, v[i].evld, v[i].ewin,
                      v[i].erdy, v[i].eerr);
        end

        // Build up state with a live drain_err, then reset between edges.
        step(0, 1, 32'h44332211, 4, 0);
        step(0, 1, 32'h00c0b0a0, 3, 7);
        check_all(100, 5'd3, 7'h07, 56'hffffffffc0b0a0, 1'b1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_all(101, 5'd0, 7'h00, ALLFF, 1'b1, 1'b0);
        drive(0, 0, 32'h0, 0, 0);
        #1;
        reset = 1'b0;
        step(0, 0, 32'h0, 0, 0);
        check_all(102, 5'd0, 7'h00, ALLFF, 1'b1, 1'b0);
        step(0, 1, 32'h0000bbaa, 2, 0);
        check_all(103, 5'd2, 7'h03, 56'hffffffffffbbaa, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
